// File: rtl/f_ifu.sv
// Instruction fetch unit: PC register, F/D pipeline register, and a skid buffer
// that parks a fetched word while D is stalled. Redirects take effect after one delay slot.
module f_ifu #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  input  logic        D_Branch,
  input  logic        D_Jump,
  input  logic        D_Jr,
  input  logic        D_cmp_eq,
  input  logic [31:0] D_rs_data,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic        D_valid
);

  typedef enum logic {StFetch, StHold} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_skid;
  logic [31:0] r_dinstr;
  logic [31:0] r_dpc;
  logic        r_dvalid;
  logic        r_redir_pending;
  logic [31:0] r_redir_pc;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_target;
  logic        w_taken;
  logic        w_accept;
  logic [31:0] w_word;
  logic [31:0] w_npc;

  always_comb begin
    w_pc4    = r_dpc + 32'd4;
    w_br_off = {{14{r_dinstr[15]}}, r_dinstr[15:0], 2'b00};
    if (D_Jr) begin
      w_target = D_rs_data;
    end else if (D_Jump) begin
      w_target = {w_pc4[31:28], r_dinstr[25:0], 2'b00};
    end else begin
      w_target = w_pc4 + w_br_off;
    end
    // A control instruction sitting in a delay slot never overrides an older redirect.
    w_taken  = r_dvalid & ~stall & (D_Jump | D_Jr | (D_Branch & D_cmp_eq)) & ~r_redir_pending;
    w_accept = ~stall & ((r_state == StHold) | im_ready);
    w_word   = (r_state == StHold) ? r_skid : im_rdata;
    if (w_taken) begin
      w_npc = w_target;
    end else if (r_redir_pending) begin
      w_npc = r_redir_pc;
    end else begin
      w_npc = r_pc + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= StFetch;
      r_pc            <= RESET_PC;
      r_skid          <= 32'd0;
      r_dinstr        <= 32'd0;
      r_dpc           <= 32'd0;
      r_dvalid        <= 1'b0;
      r_redir_pending <= 1'b0;
      r_redir_pc      <= 32'd0;
    end else if (w_accept) begin
      r_dinstr        <= w_word;
      r_dpc           <= r_pc;
      r_dvalid        <= 1'b1;
      r_pc            <= w_npc;
      r_redir_pending <= 1'b0;
      r_state         <= StFetch;
    end else if (stall) begin
      if (r_state == StFetch && im_ready) begin
        r_skid  <= im_rdata;
        r_state <= StHold;
      end
    end else begin
      // Fetch missed while D advanced: insert a bubble and remember any redirect.
      r_dvalid <= 1'b0;
      if (w_taken) begin
        r_redir_pending <= 1'b1;
        r_redir_pc      <= w_target;
      end
    end
  end

  assign im_req  = (r_state == StFetch) & ~reset;
  assign im_addr = r_pc;
  assign D_instr = r_dinstr;
  assign D_pc    = r_dpc;
  assign D_valid = r_dvalid;

endmodule

// File: tb/tb_f_ifu.sv
// Self-checking bench for f_ifu: directed scenarios plus randomized cycles compared
// against a queue-based behavioural model of the fetch/delay-slot rules.
module tb_f_ifu;

  localparam logic [31:0] ResetPc = 32'h0000_3000;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        im_req;
  logic [31:0] im_addr;
  logic        im_ready;
  logic [31:0] im_rdata;
  logic        D_Branch;
  logic        D_Jump;
  logic        D_Jr;
  logic        D_cmp_eq;
  logic [31:0] D_rs_data;
  logic [31:0] D_instr;
  logic [31:0] D_pc;
  logic        D_valid;

  int n_tests = 0;
  int n_fail  = 0;

  f_ifu #(.RESET_PC(ResetPc)) u_dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .im_req   (im_req),
    .im_addr  (im_addr),
    .im_ready (im_ready),
    .im_rdata (im_rdata),
    .D_Branch (D_Branch),
    .D_Jump   (D_Jump),
    .D_Jr     (D_Jr),
    .D_cmp_eq (D_cmp_eq),
    .D_rs_data(D_rs_data),
    .D_instr  (D_instr),
    .D_pc     (D_pc),
    .D_valid  (D_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: parked word and pending redirect are 0/1-entry queues.
  logic [31:0] m_pc, m_dinstr, m_dpc;
  logic        m_dvalid;
  logic [31:0] m_skid[$];
  logic [31:0] m_redir[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0000_3008: return 32'h1000_0004;  // beq, imm 4
      32'h0000_3010: return 32'h0200_0008;  // jr
      32'h3FFC_FFF8: return 32'h0C00_0010;  // jal, target field 0x10
      default:       return {a[15:0] ^ 16'hC3A5, a[17:2]};
    endcase
  endfunction

  task automatic model_step();
    logic        hold, tk;
    logic [31:0] pc4, tgt, word, nxt;
    if (reset) begin
      m_pc = ResetPc;
      m_skid.delete();
      m_redir.delete();
      m_dinstr = 32'd0;
      m_dpc = 32'd0;
      m_dvalid = 1'b0;
    end else begin
      hold = (m_skid.size() != 0);
      pc4 = m_dpc + 32'd4;
      if (D_Jr) tgt = D_rs_data;
      else if (D_Jump) tgt = {pc4[31:28], m_dinstr[25:0], 2'b00};
      else tgt = pc4 + ({{16{m_dinstr[15]}}, m_dinstr[15:0]} * 32'd4);
      tk = m_dvalid && !stall && (D_Jump || D_Jr || (D_Branch && D_cmp_eq)) &&
           (m_redir.size() == 0);
      if (!stall && (hold || im_ready)) begin
        if (hold) word = m_skid.pop_front();
        else word = im_rdata;
        if (tk) nxt = tgt;
        else if (m_redir.size() != 0) nxt = m_redir[0];
        else nxt = m_pc + 32'd4;
        m_dinstr = word;
        m_dpc = m_pc;
        m_dvalid = 1'b1;
        m_pc = nxt;
        m_redir.delete();
      end else if (stall) begin
        if (!hold && im_ready) m_skid.push_back(im_rdata);
      end else begin
        m_dvalid = 1'b0;
        if (tk) m_redir.push_back(tgt);
      end
    end
  endtask

  task automatic cyc(input logic rst, input logic st, input logic rdy, input logic br,
                     input logic jp, input logic jrr, input logic eq, input logic [31:0] rs);
    reset = rst;
    stall = st;
    im_ready = rdy;
    D_Branch = br;
    D_Jump = jp;
    D_Jr = jrr;
    D_cmp_eq = eq;
    D_rs_data = rs;
    im_rdata = word_at(im_addr);
    model_step();
    @(posedge clk);
    #1;
    check_eq("im_req", {31'd0, im_req}, {31'd0, !reset && (m_skid.size() == 0)});
    check_eq("im_addr", im_addr, m_pc);
    check_eq("D_instr", D_instr, m_dinstr);
    check_eq("D_pc", D_pc, m_dpc);
    check_eq("D_valid", {31'd0, D_valid}, {31'd0, m_dvalid});
  endtask

  task automatic step(input logic st, input logic rdy);
    cyc(1'b0, st, rdy, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; im_ready = 1'b0; im_rdata = 32'd0;
    D_Branch = 1'b0; D_Jump = 1'b0; D_Jr = 1'b0; D_cmp_eq = 1'b0; D_rs_data = 32'd0;

    // Reset state and sequential fetch
    do_reset();
    check_eq("rst_dvalid", {31'd0, D_valid}, 32'd0);
    check_eq("rst_addr", im_addr, 32'h3000);
    check_eq("rst_dpc", D_pc, 32'd0);
    step(1'b0, 1'b1); check_eq("seq0", D_pc, 32'h3000);
    check_eq("seq0_v", {31'd0, D_valid}, 32'd1);
    step(1'b0, 1'b1); check_eq("seq1", D_pc, 32'h3004);
    step(1'b0, 1'b1); check_eq("seq2", D_pc, 32'h3008);
    // Taken beq at 0x3008
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd0);
    check_eq("beq_slot", D_pc, 32'h300C);
    step(1'b0, 1'b1); check_eq("beq_tgt", D_pc, 32'h301C);

    // jr with fetch miss while it advances
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    check_eq("jr_at", D_pc, 32'h3010);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3040);
    check_eq("jr_bubble", {31'd0, D_valid}, 32'd0);
    step(1'b0, 1'b1); check_eq("jr_slot", D_pc, 32'h3014);
    step(1'b0, 1'b1); check_eq("jr_tgt", D_pc, 32'h3040);

    // Stall with ready parks the word in HOLD
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check_eq("hold_req", {31'd0, im_req}, 32'd0);
      check_eq("hold_dpc", D_pc, 32'h3040);
    end
    step(1'b0, 1'b0);
    check_eq("hold_word", D_instr, word_at(32'h3044));
    check_eq("hold_exit", {31'd0, im_req}, 32'd1);

    // Reset while in HOLD with redirect pending
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h5000);
    step(1'b1, 1'b1);
    check_eq("pend_hold", {31'd0, im_req}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    check_eq("rh_dvalid", {31'd0, D_valid}, 32'd0);
    check_eq("rh_addr", im_addr, 32'h3000);
    step(1'b0, 1'b1); check_eq("rh_d0", D_pc, 32'h3000);
    step(1'b0, 1'b1); check_eq("rh_d1", D_pc, 32'h3004);

    // jal near top of a 256MB region, then pc wrap
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3FFC_FFF8);
    step(1'b0, 1'b1); check_eq("jal_at", D_pc, 32'h3FFC_FFF8);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    check_eq("jal_slot", D_pc, 32'h3FFC_FFFC);
    step(1'b0, 1'b1); check_eq("jal_tgt", D_pc, 32'h3000_0040);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1); check_eq("wrap_hi", D_pc, 32'hFFFF_FFFC);
    step(1'b0, 1'b1); check_eq("wrap_0", D_pc, 32'h0000_0000);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 30),
          ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 15),
          ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 10),
          $urandom_range(0, 1) == 1, $urandom());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
